// File: rtl/gpio_port_if.sv
// CPU-side register bus for gpio_port: single-cycle write strobe, combinational read.
interface gpio_port_if #(
    parameter int WIDTH = 8
);
    logic             io_wr;
    logic [2:0]       io_addr;
    logic [WIDTH-1:0] io_wdata;
    logic [WIDTH-1:0] io_rdata;

    modport master (output io_wr, io_addr, io_wdata, input io_rdata);
    modport slave  (input io_wr, io_addr, io_wdata, output io_rdata);
endinterface

// File: rtl/gpio_port.sv
// General-purpose I/O port: output/direction registers, synchronised inputs, W1C edge status, level irq.
// Optional input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_port #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             resetq,
    gpio_port_if.slave       bus,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);
    localparam logic [2:0] GUARD_N = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] in_prev_q, in_prev_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [2:0]       guard_q, guard_d;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] in_filt;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rise_ev;
    logic [WIDTH-1:0] fall_ev;
    logic             edge_en;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign edge_en  = (guard_q == GUARD_N);

`ifdef GPIO_DEBOUNCE_EN
    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]          filt_q, filt_d;
    logic [WIDTH-1:0][CW-1:0]  cnt_q, cnt_d;

    // A pin must disagree with the filtered value for DEBOUNCE_CYCLES consecutive cycles to flip it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_out[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                cnt_d[i]  = '0;
                filt_d[i] = sync_out[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign in_filt = filt_q;
`else
    logic unused_db;
    assign unused_db = (DEBOUNCE_CYCLES != 0);
    assign in_filt   = sync_out;
`endif

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        if (bus.io_wr) begin
            case (bus.io_addr)
                3'd0: out_d     = bus.io_wdata;
                3'd1: dir_d     = bus.io_wdata;
                3'd3: rise_en_d = bus.io_wdata;
                3'd4: fall_en_d = bus.io_wdata;
                3'd6: out_d     = out_q | bus.io_wdata;
                3'd7: out_d     = out_q & ~bus.io_wdata;
                default: ;
            endcase
        end

        w1c       = (bus.io_wr && bus.io_addr == 3'd5) ? bus.io_wdata : '0;
        rise_ev   = in_filt & ~in_prev_q & rise_en_q & {WIDTH{edge_en}};
        fall_ev   = ~in_filt & in_prev_q & fall_en_q & {WIDTH{edge_en}};
        // New events are ORed in after the clear so a coincident event keeps its bit set.
        status_d  = (status_q & ~w1c) | rise_ev | fall_ev;
        in_prev_d = in_filt;
        sync_d    = {sync_q[SYNC_STAGES-2:0], pin_in};
        guard_d   = edge_en ? guard_q : guard_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            in_prev_q <= '0;
            sync_q    <= '0;
            guard_q   <= '0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            in_prev_q <= in_prev_d;
            sync_q    <= sync_d;
            guard_q   <= guard_d;
        end
    end

    always_comb begin
        case (bus.io_addr)
            3'd0:    bus.io_rdata = out_q;
            3'd1:    bus.io_rdata = dir_q;
            3'd2:    bus.io_rdata = in_filt;
            3'd3:    bus.io_rdata = rise_en_q;
            3'd4:    bus.io_rdata = fall_en_q;
            3'd5:    bus.io_rdata = status_q;
            default: bus.io_rdata = '0;
        endcase
    end

    assign pin_out = out_q;
    assign pin_oe  = dir_q;
    assign irq     = |status_q;
endmodule
